// File: rtl/source.sv
// Producer end of the inter-node value channel: replays a host-loaded
// sequence of 11-bit values to a sink over the ready/read handshake.
module source #(
   parameter int DEPTH = 39,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [10:0]   load_data,
   input  logic          start,
   input  logic [AW:0]   len,
   input  logic          read,
   output logic          ready,
   output logic [10:0]   out,
   output logic          done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   state_t        state, state_nxt;
   logic [10:0]   mem [DEPTH];
   logic [AW-1:0] idx, idx_nxt;
   logic [AW:0]   cnt, cnt_nxt, len_c;
   logic [10:0]   out_nxt;
   logic          ready_nxt, done_nxt;
   logic          take, last, wr, go;

   assign len_c = (len > DEPTH_L) ? DEPTH_L : len;
   assign take  = (state == RUN) && read;
   assign last  = ({1'b0, idx} == cnt - 1'b1);
   assign go    = (state != RUN) && start;
   assign wr    = load_en && (state != RUN)
                  && ({1'b0, load_addr} < DEPTH_L);

   // Store is deliberately outside the reset domain so it survives rst.
   always_ff @(posedge clk) begin
      if (wr)
         mem[load_addr] <= load_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         cnt   <= '0;
         ready <= 1'b0;
         out   <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         cnt   <= cnt_nxt;
         ready <= ready_nxt;
         out   <= out_nxt;
         done  <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE, DONE: begin
            if (start)
               state_nxt = (len_c == '0) ? DONE : RUN;
         end
         RUN: begin
            if (read && last)
               state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      idx_nxt   = idx;
      cnt_nxt   = cnt;
      ready_nxt = ready;
      out_nxt   = out;
      done_nxt  = done;
      if (go) begin
         cnt_nxt   = len_c;
         idx_nxt   = '0;
         done_nxt  = (len_c == '0);
         ready_nxt = (len_c != '0);
         if (len_c != '0)
            out_nxt = mem[0];
      end else if (take) begin
         if (last) begin
            ready_nxt = 1'b0;
            done_nxt  = 1'b1;
         end else begin
            idx_nxt = idx + 1'b1;
            out_nxt = mem[idx + 1'b1];
         end
      end
   end

endmodule

// File: tb/tb_source.sv
// Self-checking bench for source: a sink model consumes values and
// compares them against a behavioural copy of the store.
module tb_source;

   localparam int DEPTH = 39;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_en;
   logic [5:0]  load_addr;
   logic [10:0] load_data;
   logic        start;
   logic [6:0]  len;
   logic        read;
   logic        ready;
   logic [10:0] dout;
   logic        done;

   int n_tests = 0;
   int n_fail  = 0;

   logic [10:0] mem_m [DEPTH];

   source #(.DEPTH(DEPTH), .AW(6)) dut (
      .clk       (clk),
      .rst       (rst),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data),
      .start     (start),
      .len       (len),
      .read      (read),
      .ready     (ready),
      .out       (dout),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int a, input logic [10:0] d);
      load_en   = 1'b1;
      load_addr = 6'(a);
      load_data = d;
      tick;
      load_en = 1'b0;
      if (a < DEPTH)
         mem_m[a] = d;
   endtask

   task automatic do_start(input int l);
      start = 1'b1;
      len   = 7'(l);
      tick;
      start = 1'b0;
   endtask

   // Sink: wait for ready, capture out, pulse read for one cycle.
   task automatic take(input string nm, input logic [10:0] exp_v);
      int w = 0;
      repeat ($urandom_range(0, 2)) tick;
      while (ready !== 1'b1 && w < 20) begin
         tick;
         w++;
      end
      n_tests++;
      if (ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s: ready=%b after %0d cycles, required 1", nm, ready, w);
      end else if (dout !== exp_v) begin
         n_fail++;
         $display("FAIL %s: out=%0d required %0d", nm,
                  $signed(dout), $signed(exp_v));
      end
      read = 1'b1;
      tick;
      read = 1'b0;
      tick;
   endtask

   task automatic run_seq(input string nm, input int l);
      int k;
      k = (l > DEPTH) ? DEPTH : l;
      do_start(l);
      if (k > 0) begin
         n_tests++;
         if (ready !== 1'b1 || dout !== mem_m[0]) begin
            n_fail++;
            $display("FAIL %s_first: ready=%b out=%0d required 1 %0d",
                     nm, ready, $signed(dout), $signed(mem_m[0]));
         end
      end
      for (int i = 0; i < k; i++)
         take(nm, mem_m[i]);
      n_tests++;
      if (done !== 1'b1 || ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_end: done=%b ready=%b required 1 0", nm, done, ready);
      end
      if (k > 0) begin
         n_tests++;
         if (dout !== mem_m[k-1]) begin
            n_fail++;
            $display("FAIL %s_hold: out=%0d required %0d", nm,
                     $signed(dout), $signed(mem_m[k-1]));
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      #1;
      n_tests++;
      if (ready !== 1'b0 || dout !== 11'd0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: ready=%b out=%0d done=%b required 0 0 0",
                  ready, dout, done);
      end
      tick;
      tick;
      rst = 1'b0;
      tick;
   endtask

   task automatic test_zero_len;
      do_start(0);
      n_tests++;
      if (done !== 1'b1 || ready !== 1'b0 || dout !== 11'd0) begin
         n_fail++;
         $display("FAIL zero_len: done=%b ready=%b out=%0d required 1 0 0",
                  done, ready, dout);
      end
      read = 1'b1;
      tick;
      read = 1'b0;
      tick;
      n_tests++;
      if (done !== 1'b1 || ready !== 1'b0 || dout !== 11'd0) begin
         n_fail++;
         $display("FAIL zero_len_read: done=%b ready=%b out=%0d required 1 0 0",
                  done, ready, dout);
      end
   endtask

   task automatic test_basic;
      load(0, 11'd5);
      load(1, 11'(-7));
      load(2, 11'd999);
      run_seq("basic", 3);
   endtask

   task automatic test_clamp;
      run_seq("clamp", 50);
   endtask

   task automatic test_mid_run;
      do_start(3);
      take("mid0", mem_m[0]);
      load_en   = 1'b1;
      load_addr = 6'd1;
      load_data = 11'd123;
      start     = 1'b1;
      len       = 7'd2;
      tick;
      load_en = 1'b0;
      start   = 1'b0;
      n_tests++;
      if (ready !== 1'b1 || dout !== mem_m[1]) begin
         n_fail++;
         $display("FAIL mid_ignore: ready=%b out=%0d required 1 %0d",
                  ready, $signed(dout), $signed(mem_m[1]));
      end
      take("mid1", mem_m[1]);
      take("mid2", mem_m[2]);
      n_tests++;
      if (done !== 1'b1 || ready !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_done: done=%b ready=%b required 1 0", done, ready);
      end
      run_seq("mid_replay", 2);
   endtask

   task automatic test_load_start;
      logic [10:0] old;
      old       = mem_m[0];
      load_en   = 1'b1;
      load_addr = 6'd0;
      load_data = 11'd321;
      start     = 1'b1;
      len       = 7'd1;
      tick;
      load_en  = 1'b0;
      start    = 1'b0;
      mem_m[0] = 11'd321;
      n_tests++;
      if (ready !== 1'b1 || dout !== old) begin
         n_fail++;
         $display("FAIL load_start: ready=%b out=%0d required 1 %0d",
                  ready, $signed(dout), $signed(old));
      end
      take("load_start_take", old);
      run_seq("load_start_new", 1);
      load(0, 11'd5);
   endtask

   task automatic test_rst_mid;
      do_start(3);
      take("rst_first", mem_m[0]);
      rst = 1'b1;
      #1;
      n_tests++;
      if (ready !== 1'b0 || dout !== 11'd0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid: ready=%b out=%0d done=%b required 0 0 0",
                  ready, dout, done);
      end
      tick;
      rst = 1'b0;
      tick;
      run_seq("rst_replay", 3);
   endtask

   task automatic test_hold;
      do_start(3);
      for (int i = 0; i < 10; i++) begin
         tick;
         n_tests++;
         if (ready !== 1'b1 || dout !== mem_m[0]) begin
            n_fail++;
            $display("FAIL hold_%0d: ready=%b out=%0d required 1 %0d",
                     i, ready, $signed(dout), $signed(mem_m[0]));
         end
      end
      read = 1'b1;
      tick;
      read = 1'b0;
      n_tests++;
      if (ready !== 1'b1 || dout !== mem_m[1]) begin
         n_fail++;
         $display("FAIL hold_advance: ready=%b out=%0d required 1 %0d",
                  ready, $signed(dout), $signed(mem_m[1]));
      end
      tick;
      take("hold1", mem_m[1]);
      take("hold2", mem_m[2]);
      n_tests++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_done: done=%b required 1", done);
      end
   endtask

   task automatic test_random;
      for (int r = 0; r < 6; r++) begin
         repeat ($urandom_range(1, 6))
            load($urandom_range(0, 63), 11'($urandom));
         run_seq("rand", $urandom_range(0, 60));
      end
   endtask

   initial begin
      rst       = 1'b1;
      load_en   = 1'b0;
      load_addr = '0;
      load_data = '0;
      start     = 1'b0;
      len       = '0;
      read      = 1'b0;
      test_reset;
      for (int i = 0; i < DEPTH; i++)
         load(i, 11'($urandom));
      test_zero_len;
      test_basic;
      test_clamp;
      test_mid_run;
      test_load_start;
      test_rst_mid;
      test_hold;
      test_random;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/source.md
# source

Producer end of the inter-node value channel: plays a stored sequence of 11-bit TIS values to a consumer over the `ready`/`read` handshake. The consuming `sink` samples `ready`/`out` and pulses `read` for one cycle per value taken. The sequence is written through a host load port, then replayed on `start`. It sits at puzzle input ports and feeds test vectors into the node array.

## Interface
- `DEPTH`, 39: number of value slots. 39 matches a TIS puzzle input stream.
- `AW`, 6: address width. Must satisfy 2^AW ≥ DEPTH.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `load_en`  in  1  write strobe for the value store.
- `load_addr`  in  AW  write slot index.
- `load_data`  in  11  value to store, two's complement (-999..999 by convention; not checked).
- `start`  in  1  begin playback from slot 0.
- `len`  in  AW+1  number of values to play; sampled on `start`.
- `read`  in  1  consumer acknowledge; one-cycle pulse per value taken.
- `ready`  out  1  `out` holds a valid, untaken value.
- `out`  out  11  current value.
- `done`  out  1  the last value of the sequence has been taken.

## Operation
- Store: DEPTH × 11-bit array, asynchronous read, not reset, contents retained across `rst` and playbacks.
  - Write when `load_en` and state is not RUN.
  - `load_addr` ≥ DEPTH: the write is dropped.
- Registers: state ∈ {IDLE, RUN, DONE}, `idx` (AW bits), `cnt` (AW+1 bits), `ready`, `out`, `done`.
- Reset values: state = IDLE, `idx` = 0, `cnt` = 0, `ready` = 0, `out` = 0, `done` = 0.
- IDLE or DONE with `start`=1:
  - `cnt` ← min(`len`, DEPTH); `idx` ← 0; `done` ← 0.
  - If the clamped length is 0: state ← DONE, `done` ← 1, `ready` stays 0.
  - Otherwise: state ← RUN, `ready` ← 1, `out` ← mem[0].
- RUN, `read`=1 (`ready` is necessarily 1):
  - If `idx` = `cnt`-1: `ready` ← 0, `done` ← 1, state ← DONE; `out` keeps the last value.
  - Otherwise: `idx` ← `idx`+1, `out` ← mem[`idx`+1], `ready` stays 1.
- RUN, `read`=0: hold all registers.
- `read` while `ready`=0 (IDLE/DONE): ignored, no state change.
- `start` during RUN: ignored.
- `load_en` in the same cycle as `start` from IDLE/DONE: the write occurs. If it targets slot 0, `out` gets the pre-write value (asynchronous read before the edge).
- `done` is a level: held in DONE until the next accepted `start` or `rst`.
- `out` holds its last value whenever `ready`=0.

## Timing
- `start` sampled at edge k: `ready`=1, `out`=mem[0] visible from cycle k+1.
- Handshake: the consumer sees `ready`=1 at edge n and drives `read`=1 during cycle n+1. The source samples `read` at edge n+1. The next value, or `ready`=0, is visible from cycle n+2, the same cycle `read` returns low. The consumer samples it at edge n+2.
- Throughput: one value per 2 cycles with a back-to-back sink.
- Latency from the last `read` edge to `done`=1: 0 cycles; visible the cycle after the sampling edge.
- `rst` asserted mid-RUN: outputs clear immediately (asynchronously). After release, the block is IDLE and the store is intact. A new `start` replays from slot 0.
- `read` held high for more than one cycle: each high cycle consumes one value. The protocol forbids this; no protection is provided.

## Test plan
- Load slots 0..2 with 5, -7, 999; `start` with `len`=3; connect `sink` → sink captures 5, -7, 999 on successive reads 2 cycles apart. `done`=1 after the third read; `ready`=0, `out`=999.
- `start` with `len`=0 → next cycle `done`=1, `ready`=0. A `read` pulse is ignored. `out` stays at its reset value 0.
- `len`=50 with DEPTH=39 → exactly 39 values delivered (slots 0..38), then `done`.
- Mid-RUN behaviour:
  - `load_en` to slot 1 with 123 and `start` during RUN → both ignored; the original slot-1 value is delivered.
  - After DONE, `start` `len`=2 → replays slots 0, 1.
- Assert `rst` after the first read of a 3-value run → `ready`, `out`, `done` = 0 immediately. After release, `start` `len`=3 → 5, -7, 999 again (store retained).
- Hold `read` low for 10 cycles with `ready`=1 → `out`, `idx`, `ready` unchanged. Then one `read` pulse → exactly one advance.
